// File: rtl/ff_fifo_pkg.sv
// Shared sizing helpers for the any-depth FIFO family.
package ff_fifo_pkg;

  function automatic int count_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int ptr_w(input int depth);
    return ($clog2(depth) > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/ff_fifo_wrap_ptr.sv
// Modulo-depth pointer: advances on inc, wraps from depth-1 to 0 by explicit compare.
module ff_fifo_wrap_ptr
  import ff_fifo_pkg::*;
#(
  parameter int depth = 5
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      inc,
  output logic [ptr_w(depth)-1:0]   ptr
);

  localparam int PW = ptr_w(depth);
  localparam logic [PW-1:0] LAST = PW'(depth - 1);

  always_ff @(posedge clk) begin
    if (rst)
      ptr <= '0;
    else if (inc)
      ptr <= (ptr == LAST) ? '0 : ptr + PW'(1);
  end

endmodule

// File: rtl/ff_fifo_any_depth_flags.sv
// Single-clock FIFO of arbitrary depth with occupancy count, programmable
// almost flags and sticky overflow/underflow reporting of dropped requests.
module ff_fifo_any_depth_flags
  import ff_fifo_pkg::*;
#(
  parameter int width              = 8,
  parameter int depth              = 5,
  parameter int almost_full_level  = depth - 1,
  parameter int almost_empty_level = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [width-1:0]           write_data,
  output logic [width-1:0]           read_data,
  output logic                       empty,
  output logic                       full,
  output logic                       almost_empty,
  output logic                       almost_full,
  output logic [count_w(depth)-1:0]  count,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int CW = count_w(depth);
  localparam int PW = ptr_w(depth);

  if (width < 1) begin : g_bad_width
    $error("ff_fifo_any_depth_flags: width must be >= 1");
  end
  if (depth < 2) begin : g_bad_depth
    $error("ff_fifo_any_depth_flags: depth must be >= 2");
  end
  if (almost_full_level < 1 || almost_full_level > depth) begin : g_bad_afl
    $error("ff_fifo_any_depth_flags: almost_full_level must be in 1..depth");
  end
  if (almost_empty_level < 0 || almost_empty_level > depth - 1) begin : g_bad_ael
    $error("ff_fifo_any_depth_flags: almost_empty_level must be in 0..depth-1");
  end

  logic [width-1:0] mem [depth];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  // Guard decisions use flags decoded from the pre-edge count.
  always_comb begin
    push_ok = push & ~full;
    pop_ok  = pop & ~empty;
  end

  ff_fifo_wrap_ptr #(.depth(depth)) u_wr_ptr (
    .clk (clk),
    .rst (rst),
    .inc (push_ok),
    .ptr (wr_ptr)
  );

  ff_fifo_wrap_ptr #(.depth(depth)) u_rd_ptr (
    .clk (clk),
    .rst (rst),
    .inc (pop_ok),
    .ptr (rd_ptr)
  );

  always_ff @(posedge clk) begin
    if (push_ok)
      mem[wr_ptr] <= write_data;
  end

  always_ff @(posedge clk) begin
    if (rst)
      count <= '0;
    else if (push_ok && !pop_ok)
      count <= count + CW'(1);
    else if (pop_ok && !push_ok)
      count <= count - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (push && full)
        overflow <= 1'b1;
      if (pop && empty)
        underflow <= 1'b1;
    end
  end

  always_comb begin
    read_data    = mem[rd_ptr];
    empty        = (count == '0);
    full         = (count == CW'(depth));
    almost_empty = (count <= CW'(almost_empty_level));
    almost_full  = (count >= CW'(almost_full_level));
  end

endmodule

// File: tb/tb_ff_fifo_any_depth_flags.sv
// Scenario bench for ff_fifo_any_depth_flags (width 8, depth 5) against a queue model.
module tb_ff_fifo_any_depth_flags;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       push = 1'b0;
  logic       pop = 1'b0;
  logic [7:0] write_data = '0;
  logic [7:0] read_data;
  logic       empty, full, almost_empty, almost_full;
  logic [2:0] count;
  logic       overflow, underflow;

  int unsigned n_cmp  = 0;
  int unsigned n_fail = 0;

  byte unsigned q[$];
  bit           m_ovf = 1'b0;
  bit           m_unf = 1'b0;

  always #5 clk = ~clk;

  ff_fifo_any_depth_flags #(.width(8), .depth(5)) dut (
    .clk          (clk),
    .rst          (rst),
    .push         (push),
    .pop          (pop),
    .write_data   (write_data),
    .read_data    (read_data),
    .empty        (empty),
    .full         (full),
    .almost_empty (almost_empty),
    .almost_full  (almost_full),
    .count        (count),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  // One clock with the given requests; the model applies the same edge.
  task automatic step(input bit p, input bit o, input logic [7:0] d);
    bit can_push, can_pop;
    push = p; pop = o; write_data = d;
    @(posedge clk);
    if (rst) begin
      q.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else begin
      can_push = p && (q.size() < 5);
      can_pop  = o && (q.size() > 0);
      if (p && !can_push) m_ovf = 1'b1;
      if (o && q.size() == 0) m_unf = 1'b1;
      if (can_pop) void'(q.pop_front());
      if (can_push) q.push_back(d);
    end
    #1;
    push = 1'b0; pop = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    step(0, 0, 8'h00);
    step(0, 0, 8'h00);
    rst = 1'b0;
    n_cmp++;
    if ({count, empty, full, almost_empty, almost_full, overflow, underflow} !== {3'd0, 6'b101000}) begin
      n_fail++;
      $display("FAIL reset_state: got count=%0d e=%b f=%b ae=%b af=%b ov=%b un=%b, want count=0 e=1 f=0 ae=1 af=0 ov=0 un=0",
               count, empty, full, almost_empty, almost_full, overflow, underflow);
    end
  endtask

  task automatic test_fill;
    for (int i = 0; i < 5; i++) begin
      step(1, 0, 8'(8'h11 + i));
      n_cmp++;
      if (count !== 3'(i + 1) || read_data !== 8'h11 || almost_full !== (i + 1 >= 4) || full !== (i + 1 == 5)) begin
        n_fail++;
        $display("FAIL fill[%0d]: got count=%0d rd=%h af=%b f=%b, want count=%0d rd=11 af=%b f=%b",
                 i, count, read_data, almost_full, full, i + 1, (i + 1 >= 4), (i + 1 == 5));
      end
    end
  endtask

  task automatic test_drain;
    for (int i = 0; i < 5; i++) begin
      n_cmp++;
      if (read_data !== 8'(8'h11 + i)) begin
        n_fail++;
        $display("FAIL drain_data[%0d]: got %h want %h", i, read_data, 8'(8'h11 + i));
      end
      step(0, 1, 8'h00);
      n_cmp++;
      if (count !== 3'(4 - i) || empty !== (i == 4) || almost_empty !== (4 - i <= 1)) begin
        n_fail++;
        $display("FAIL drain_flags[%0d]: got count=%0d e=%b ae=%b, want count=%0d e=%b ae=%b",
                 i, count, empty, almost_empty, 4 - i, (i == 4), (4 - i <= 1));
      end
    end
  endtask

  task automatic test_back_to_back;
    for (int i = 0; i < 3; i++) step(1, 0, 8'(8'h20 + i));
    for (int i = 0; i < 12; i++) begin
      n_cmp++;
      if (read_data !== 8'(8'h20 + i)) begin
        n_fail++;
        $display("FAIL stream_data[%0d]: got %h want %h", i, read_data, 8'(8'h20 + i));
      end
      step(1, 1, 8'(8'h23 + i));
      n_cmp++;
      if (count !== 3'd3) begin
        n_fail++;
        $display("FAIL stream_count[%0d]: got %0d want 3", i, count);
      end
    end
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (read_data !== 8'(8'h2C + i)) begin
        n_fail++;
        $display("FAIL stream_tail[%0d]: got %h want %h", i, read_data, 8'(8'h2C + i));
      end
      step(0, 1, 8'h00);
    end
  endtask

  task automatic test_overflow;
    for (int i = 0; i < 5; i++) step(1, 0, 8'(8'h31 + i));
    step(1, 0, 8'hAA);
    n_cmp++;
    if (overflow !== 1'b1 || count !== 3'd5 || read_data !== 8'h31) begin
      n_fail++;
      $display("FAIL ovf_push: got ov=%b count=%0d rd=%h, want ov=1 count=5 rd=31", overflow, count, read_data);
    end
    step(1, 1, 8'hBB);
    n_cmp++;
    if (count !== 3'd4 || read_data !== 8'h32 || full !== 1'b0) begin
      n_fail++;
      $display("FAIL ovf_pushpop: got count=%0d rd=%h f=%b, want count=4 rd=32 f=0", count, read_data, full);
    end
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (read_data !== 8'(8'h32 + i)) begin
        n_fail++;
        $display("FAIL ovf_drain[%0d]: got %h want %h", i, read_data, 8'(8'h32 + i));
      end
      step(0, 1, 8'h00);
    end
    n_cmp++;
    if (empty !== 1'b1 || underflow !== 1'b0) begin
      n_fail++;
      $display("FAIL ovf_end: got e=%b un=%b want e=1 un=0", empty, underflow);
    end
  endtask

  task automatic test_underflow;
    step(0, 1, 8'h00);
    n_cmp++;
    if (underflow !== 1'b1 || count !== 3'd0 || empty !== 1'b1) begin
      n_fail++;
      $display("FAIL unf_pop: got un=%b count=%0d e=%b want un=1 count=0 e=1", underflow, count, empty);
    end
    step(1, 1, 8'h5A);
    n_cmp++;
    if (count !== 3'd1 || read_data !== 8'h5A || empty !== 1'b0 || underflow !== 1'b1) begin
      n_fail++;
      $display("FAIL unf_pushpop: got count=%0d rd=%h e=%b un=%b want count=1 rd=5a e=0 un=1",
               count, read_data, empty, underflow);
    end
  endtask

  task automatic test_reset_mid;
    step(1, 0, 8'h61);
    step(1, 0, 8'h62);
    n_cmp++;
    if (count !== 3'd3 || overflow !== 1'b1) begin
      n_fail++;
      $display("FAIL prereset: got count=%0d ov=%b want count=3 ov=1", count, overflow);
    end
    rst = 1'b1;
    step(0, 0, 8'h00);
    rst = 1'b0;
    n_cmp++;
    if (count !== 3'd0 || empty !== 1'b1 || overflow !== 1'b0 || underflow !== 1'b0 || almost_empty !== 1'b1) begin
      n_fail++;
      $display("FAIL midreset: got count=%0d e=%b ov=%b un=%b ae=%b want count=0 e=1 ov=0 un=0 ae=1",
               count, empty, overflow, underflow, almost_empty);
    end
  endtask

  task automatic test_random;
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 99) == 0);
      step(1'($urandom_range(0, 99) < 55), 1'($urandom_range(0, 99) < 50), 8'($urandom));
      rst = 1'b0;
      n_cmp++;
      if (count !== 3'(q.size()) || empty !== (q.size() == 0) || full !== (q.size() == 5) ||
          almost_empty !== (q.size() <= 1) || almost_full !== (q.size() >= 4) ||
          overflow !== m_ovf || underflow !== m_unf ||
          (q.size() > 0 && read_data !== q[0])) begin
        n_fail++;
        $display("FAIL random[%0d]: got count=%0d e=%b f=%b ae=%b af=%b ov=%b un=%b rd=%h, want count=%0d ov=%b un=%b rd=%h",
                 i, count, empty, full, almost_empty, almost_full, overflow, underflow, read_data,
                 q.size(), m_ovf, m_unf, (q.size() > 0) ? q[0] : 8'h00);
      end
    end
  endtask

  initial begin
    test_reset;
    test_fill;
    test_drain;
    test_back_to_back;
    test_overflow;
    test_underflow;
    test_reset_mid;
    test_random;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
